// File: rtl/stage_pipe_reg_pkg.sv
// Shared pipeline definitions: stage state encoding, zero constants and occupancy decode.
package stage_pipe_reg_pkg;

  // Encodings double as the entry count held in each state.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull1 = 2'd1,
    StFull2 = 2'd2
  } pipe_state_e;

  localparam int unsigned MaxW = 256;
  localparam logic [MaxW-1:0] ZeroWord = '0;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    unique case (s)
      StEmpty: occ = 2'd0;
      StFull1: occ = 2'd1;
      StFull2: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/stage_pipe_reg.sv
// Valid/ready pipeline stage register with flush. Define STAGE_PIPE_SKID_EN to add a skid
// entry that makes in_ready a registered signal independent of out_ready.
module stage_pipe_reg
  import stage_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  if (DATA_W < 1 || DATA_W > MaxW) begin : g_bad_data_w
    $error("stage_pipe_reg: DATA_W must be in 1..256");
  end
  if (TAG_W < 1 || TAG_W > MaxW) begin : g_bad_tag_w
    $error("stage_pipe_reg: TAG_W must be in 1..256");
  end

  pipe_state_e       state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [TAG_W-1:0]  main_tag_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state_occupancy(state_q);

  // Main is zeroed on every path to empty; the mux keeps outputs clean regardless.
  assign out_data = out_valid ? main_data_q : ZeroWord[DATA_W-1:0];
  assign out_tag  = out_valid ? main_tag_q  : ZeroWord[TAG_W-1:0];

`ifdef STAGE_PIPE_SKID_EN

  logic [DATA_W-1:0] skid_data_q;
  logic [TAG_W-1:0]  skid_tag_q;
  logic              ready_q;

  // ready_q tracks (next state != FULL2); only rst gates it combinationally.
  assign in_ready = ready_q && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= StEmpty;
      main_data_q <= ZeroWord[DATA_W-1:0];
      main_tag_q  <= ZeroWord[TAG_W-1:0];
      skid_data_q <= ZeroWord[DATA_W-1:0];
      skid_tag_q  <= ZeroWord[TAG_W-1:0];
      ready_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StFull1;
            main_data_q <= in_data;
            main_tag_q  <= in_tag;
          end
        end
        StFull1: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_tag_q  <= in_tag;
          end else if (out_fire) begin
            state_q     <= StEmpty;
            main_data_q <= ZeroWord[DATA_W-1:0];
            main_tag_q  <= ZeroWord[TAG_W-1:0];
          end else if (in_fire) begin
            state_q     <= StFull2;
            skid_data_q <= in_data;
            skid_tag_q  <= in_tag;
            ready_q     <= 1'b0;
          end
        end
        StFull2: begin
          if (out_fire) begin
            state_q     <= StFull1;
            main_data_q <= skid_data_q;
            main_tag_q  <= skid_tag_q;
            skid_data_q <= ZeroWord[DATA_W-1:0];
            skid_tag_q  <= ZeroWord[TAG_W-1:0];
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_data_q <= ZeroWord[DATA_W-1:0];
          main_tag_q  <= ZeroWord[TAG_W-1:0];
          skid_data_q <= ZeroWord[DATA_W-1:0];
          skid_tag_q  <= ZeroWord[TAG_W-1:0];
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

`else

  // Without a skid slot an entry can only enter when main is free or draining.
  assign in_ready = !rst && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= StEmpty;
      main_data_q <= ZeroWord[DATA_W-1:0];
      main_tag_q  <= ZeroWord[TAG_W-1:0];
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StFull1;
            main_data_q <= in_data;
            main_tag_q  <= in_tag;
          end
        end
        StFull1: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_tag_q  <= in_tag;
          end else if (out_fire) begin
            state_q     <= StEmpty;
            main_data_q <= ZeroWord[DATA_W-1:0];
            main_tag_q  <= ZeroWord[TAG_W-1:0];
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_data_q <= ZeroWord[DATA_W-1:0];
          main_tag_q  <= ZeroWord[TAG_W-1:0];
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Scoreboard bench for stage_pipe_reg: accepted inputs queue expected entries, a negedge
// monitor pops on each downstream transfer; directed checks cover handshake and flush/reset.
module tb_stage_pipe_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        occupancy;

  always #5 clk = ~clk;

  stage_pipe_reg #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t sb[$];
  entry_t mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop before push: a freshly accepted entry cannot appear at the output this cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got data 0x%0h tag 0x%0h, expected no output",
                 out_data, out_tag);
      end else begin
        mon_e = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(mon_e.data));
        check("sb_tag", 64'(out_tag), 64'(mon_e.tag));
      end
    end
    if (!rst && !flush && in_valid && in_ready) begin
      sb.push_back('{data: in_data, tag: in_tag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_data  = d;
    in_tag   = t;
  endtask

  task automatic check_empty(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_data"}, 64'(out_data), 64'd0);
    check({name, "_tag"}, 64'(out_tag), 64'd0);
    check({name, "_occ"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    offer(1'b0, '0, '0);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    check_empty("rst");
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single entry, one-cycle latency
    offer(1'b1, 32'h1234, 32'hBFC0_0000);
    tick();
    offer(1'b0, '0, '0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'h1234);
    check("first_tag", 64'(out_tag), 64'hBFC0_0000);
    check("first_occ", 64'(occupancy), 64'd1);
    tick();
    check_empty("drained");

    // Back-to-back stream, no bubbles
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, DATA_W'(i), 32'h8000_0000 + TAG_W'(i));
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(i));
    end
    offer(1'b0, '0, '0);
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);

`ifdef STAGE_PIPE_SKID_EN
    // Fill main and skid under stall, then drain in order
    out_ready = 1'b0;
    offer(1'b1, 32'hA, 32'hA0);
    tick();
    offer(1'b1, 32'hB, 32'hB0);
    tick();
    offer(1'b0, '0, '0);
    #1;
    check("skid_occ", 64'(occupancy), 64'd2);
    check("skid_in_ready", 64'(in_ready), 64'd0);
    check("skid_head_data", 64'(out_data), 64'hA);
    tick();
    check("skid_stall_data", 64'(out_data), 64'hA);
    check("skid_stall_tag", 64'(out_tag), 64'hA0);
    out_ready = 1'b1;
    tick();
    check("skid_second_data", 64'(out_data), 64'hB);
    check("skid_second_occ", 64'(occupancy), 64'd1);
    tick();
    check("skid_empty_occ", 64'(occupancy), 64'd0);

    // Flush from FULL2 with a simultaneous offer
    out_ready = 1'b0;
    offer(1'b1, 32'hD, 32'hD0);
    tick();
    offer(1'b1, 32'hE, 32'hE0);
    tick();
    check("pre_flush_occ", 64'(occupancy), 64'd2);
    offer(1'b1, 32'hC, 32'hC0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, '0, '0);
    sb.delete();
    check_empty("flush");
    out_ready = 1'b1;
    tick();
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // Reset during FULL2 with flush
    out_ready = 1'b0;
    offer(1'b1, 32'hF, 32'hF0);
    tick();
    offer(1'b1, 32'h10, 32'h100);
    tick();
    check("pre_rst_occ", 64'(occupancy), 64'd2);
    offer(1'b1, 32'h11, 32'h110);
    flush = 1'b1;
    rst   = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_empty("mid_rst");
    rst   = 1'b0;
    flush = 1'b0;
    offer(1'b0, '0, '0);
    sb.delete();
`else
    // Stall blocks intake; out_ready reopens it as a pass-through
    out_ready = 1'b0;
    offer(1'b1, 32'hA, 32'hA0);
    tick();
    offer(1'b1, 32'hB, 32'hB0);
    #1;
    check("ns_stall_in_ready", 64'(in_ready), 64'd0);
    check("ns_stall_occ", 64'(occupancy), 64'd1);
    tick();
    check("ns_hold_data", 64'(out_data), 64'hA);
    check("ns_hold_tag", 64'(out_tag), 64'hA0);
    out_ready = 1'b1;
    #1;
    check("ns_pass_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("ns_pass_data", 64'(out_data), 64'hB);
    check("ns_pass_occ", 64'(occupancy), 64'd1);
    offer(1'b0, '0, '0);
    tick();
    check("ns_empty_occ", 64'(occupancy), 64'd0);

    // Flush from FULL1 with a simultaneous offer
    out_ready = 1'b0;
    offer(1'b1, 32'hD, 32'hD0);
    tick();
    offer(1'b1, 32'hC, 32'hC0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, '0, '0);
    sb.delete();
    check_empty("flush");
    out_ready = 1'b1;
    tick();
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // Reset during FULL1 with flush
    out_ready = 1'b0;
    offer(1'b1, 32'hF, 32'hF0);
    tick();
    offer(1'b1, 32'h10, 32'h100);
    flush = 1'b1;
    rst   = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check_empty("mid_rst");
    rst   = 1'b0;
    flush = 1'b0;
    offer(1'b0, '0, '0);
    sb.delete();
`endif

    // Recovery after reset, then drain whatever remains
    out_ready = 1'b1;
    offer(1'b1, 32'h55, 32'h550);
    tick();
    offer(1'b0, '0, '0);
    check("recover_data", 64'(out_data), 64'h55);
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
